// File: rtl/mult_arbiter.sv
// mult_arbiter: shared signed multiplier with a built-in round-robin mutex.
// Clients request the mutex, present operands, hold start and wait for a
// one-cycle done pulse; the product is broadcast to all clients.
// Optional build macro MULT_ARB_FAST_EN: replaces the shift-add loop with a
// single-cycle combinational multiply (done two edges after start).
module mult_arbiter #(
    parameter int NumClients = 5,
    parameter int DataWidth  = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic [NumClients-1:0]           mult_req_i,
    output logic [NumClients-1:0]           mult_grant_o,
    input  logic [NumClients-1:0]           mult_start_i,
    input  logic [NumClients*DataWidth-1:0] mult_a_i,
    input  logic [NumClients*DataWidth-1:0] mult_b_i,
    output logic [2*DataWidth-1:0]          mult_result_o,
    output logic [NumClients-1:0]           mult_done_o,
    output logic                            mult_busy_o
);

    localparam int IdxW  = (NumClients > 1) ? $clog2(NumClients) : 1;
    localparam int CntW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam int ProdW = 2 * DataWidth;

    localparam logic [IdxW-1:0] RrReset = IdxW'(NumClients - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DataWidth - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_RUN,
        ST_FINISH,
        ST_RELEASE
    } state_e;

    state_e                r_state;
    state_e                w_state_next;

    logic [NumClients-1:0] r_grant;
    logic [IdxW-1:0]       r_rr;        // last granted client, also the current owner
    logic [DataWidth-1:0]  r_mag_a;
    logic [DataWidth-1:0]  r_mag_b;
    logic                  r_sign;
    logic [ProdW-1:0]      r_acc;
    logic [CntW-1:0]       r_cnt;
    logic                  r_busy;
    logic [NumClients-1:0] r_done;
    logic [ProdW-1:0]      r_result;

    logic                  w_any_req;
    logic [IdxW-1:0]       w_pick;
    logic [NumClients-1:0] w_pick_onehot;
    logic                  w_req_own;
    logic                  w_start_own;
    logic [DataWidth-1:0]  w_a_sel;
    logic [DataWidth-1:0]  w_b_sel;
    logic [DataWidth-1:0]  w_mag_a;
    logic [DataWidth-1:0]  w_mag_b;
    logic                  w_sign;
    logic [ProdW-1:0]      w_partial;
    logic                  w_grant_set;
    logic                  w_grant_clr;
    logic                  w_op_start;
    logic                  w_step;
    logic                  w_finish;

    // Only the grant holder's request and start bits matter.
    assign w_req_own   = |(mult_req_i & r_grant);
    assign w_start_own = |(mult_start_i & r_grant);

    // Magnitudes are unsigned, so the most negative operand maps to 2^(DataWidth-1).
    assign w_mag_a = w_a_sel[DataWidth-1] ? -w_a_sel : w_a_sel;
    assign w_mag_b = w_b_sel[DataWidth-1] ? -w_b_sel : w_b_sel;
    assign w_sign  = w_a_sel[DataWidth-1] ^ w_b_sel[DataWidth-1];

    // Shifted multiplicand for the current shift-add step.
    assign w_partial = ProdW'(r_mag_a) << r_cnt;

    assign w_pick_onehot = NumClients'(1) << w_pick;

`ifdef MULT_ARB_FAST_EN
    logic [ProdW-1:0] w_fast_prod;
    assign w_fast_prod = ProdW'(w_mag_a) * ProdW'(w_mag_b);
`endif

    // Round-robin search: first requester strictly after the last owner, wrapping.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        idx       = 0;
        w_any_req = 1'b0;
        w_pick    = r_rr;
        for (int i = 1; i <= NumClients; i++) begin
            idx = int'(r_rr) + i;
            if (idx >= NumClients) idx = idx - NumClients;
            if (!w_any_req && mult_req_i[IdxW'(idx)]) begin
                w_any_req = 1'b1;
                w_pick    = IdxW'(idx);
            end
        end
    end

    // Operand mux for the grant holder.
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int k = 0; k < NumClients; k++) begin
            if (r_grant[k]) begin
                w_a_sel = mult_a_i[k*DataWidth +: DataWidth];
                w_b_sel = mult_b_i[k*DataWidth +: DataWidth];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_ni) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_grant_set  = 1'b0;
        w_grant_clr  = 1'b0;
        w_op_start   = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_set  = 1'b1;
                    w_state_next = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (!w_req_own) begin
                    w_grant_clr  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_start_own) begin
                    w_op_start   = 1'b1;
`ifdef MULT_ARB_FAST_EN
                    w_state_next = ST_FINISH;
`else
                    w_state_next = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CntLast) w_state_next = ST_FINISH;
            end
            ST_FINISH: begin
                w_finish     = 1'b1;
                w_state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Start still held must not restart; only dropping req frees the mutex.
                if (!w_req_own) begin
                    w_grant_clr  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Grant, operand capture, shift-add accumulation and result/done outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_grant  <= '0;
            r_rr     <= RrReset;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_sign   <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= '0;
            r_result <= '0;
        end else begin
            r_done <= '0;
            if (w_grant_set) begin
                r_grant <= w_pick_onehot;
                r_rr    <= w_pick;
            end
            if (w_grant_clr) r_grant <= '0;
            if (w_op_start) begin
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_sign  <= w_sign;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
`ifdef MULT_ARB_FAST_EN
                r_acc   <= w_fast_prod;
`else
                r_acc   <= '0;
`endif
            end
            if (w_step) begin
                if (r_mag_b[0]) r_acc <= r_acc + w_partial;
                r_mag_b <= r_mag_b >> 1;
                r_cnt   <= r_cnt + CntW'(1);
            end
            if (w_finish) begin
                r_result <= r_sign ? -r_acc : r_acc;
                r_done   <= r_grant;
                r_busy   <= 1'b0;
            end
        end
    end

    assign mult_grant_o  = r_grant;
    assign mult_done_o   = r_done;
    assign mult_busy_o   = r_busy;
    assign mult_result_o = r_result;

endmodule
